// File: rtl/rom_loader_pkg.sv
// Shared constants, FSM state encoding, write-buffer entry type and the bank-mask
// helper for rom_loader.
package rom_loader_pkg;

    localparam int ROM_ADDR_W = 22;
    localparam int BANK_BITS  = 14;
    localparam int HDR_BYTES  = 512;
    localparam int MASK_W     = ROM_ADDR_W - BANK_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        CALC1 = 3'd3,
        CALC2 = 3'd4,
        READY = 3'd5
    } state_t;

    typedef struct packed {
        logic [ROM_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } wr_entry_t;

    // Smallest all-ones mask covering `banks` banks; saturates at all-ones.
    function automatic logic [MASK_W-1:0] next_pow2_mask(input logic [MASK_W:0] banks);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (({1'b0, m} + (MASK_W+1)'(1)) < banks) begin
                m = {m[MASK_W-2:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rom_loader_wbuf.sv
// Two-entry write FIFO; the head always lives in slot 0 so its outputs come
// straight from registers.
module rom_loader_wbuf
    import rom_loader_pkg::*;
(
    input  logic      clk_sys,
    input  logic      reset,
    input  logic      push_i,
    input  wr_entry_t din_i,
    input  logic      pop_i,
    output wr_entry_t head_o,
    output logic      full_o,
    output logic      empty_o,
    output logic      drop_o
);

    wr_entry_t  e0_q, e1_q;
    logic [1:0] cnt_q;
    logic       do_pop_s, do_push_s;

    assign do_pop_s  = pop_i & (cnt_q != 2'd0);
    assign do_push_s = push_i & ((cnt_q != 2'd2) | do_pop_s);
    assign drop_o    = push_i & ~do_push_s;
    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);
    assign head_o    = e0_q;

    // Shift-style storage: a pop moves slot 1 into slot 0.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_q <= din_i;
                    end else begin
                        e1_q <= din_i;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= din_i;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din_i;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/rom_loader.sv
// ROM download pacing into SDRAM, image sizing/bank-mask calculation and ROM read
// address translation. Copier-header stripping is enabled by ROM_LOADER_HEADER_STRIP_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W    = rom_loader_pkg::ROM_ADDR_W,
    parameter int BANK_BITS = rom_loader_pkg::BANK_BITS,
    parameter int HDR_BYTES = rom_loader_pkg::HDR_BYTES
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        ioctl_download,
    input  logic                        ioctl_wr,
    input  logic [24:0]                 ioctl_addr,
    input  logic [7:0]                  ioctl_dout,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_waddr,
    output logic [7:0]                  mem_din,
    input  logic                        rom_rd,
    input  logic [ADDR_W-1:0]           rom_a,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_raddr,
    output logic [ADDR_W-BANK_BITS-1:0] cart_mask,
    output logic                        rom_valid,
    output logic                        overflow
);

    localparam int CM_W = ADDR_W - BANK_BITS;
    localparam logic [ADDR_W:0] HDR_SZ = (ADDR_W+1)'(HDR_BYTES);

    state_t              state_q;
    logic                dl_q;
    logic [ADDR_W-1:0]   max_addr_q;
    logic                any_wr_q;
    logic [ADDR_W:0]     payload_q;
    logic                hdr_q;
    logic [CM_W-1:0]     cart_mask_q;
    logic                rom_valid_q;
    logic                overflow_q;
    logic [ADDR_W-1:0]   hdr_off_q;
    logic                mem_rd_q;
    logic [ADDR_W-1:0]   mem_raddr_q;

    logic                dl_rise_s, push_s, wb_empty_s, wb_drop_s;
    logic                unused_full_s, unused_hi_s;
    wr_entry_t           wb_in_s, wb_head_s;
    logic [ADDR_W:0]     size_d, payload_d;
    logic                hdr_d;
    logic [CM_W:0]       banks_d;
    logic [CM_W-1:0]     cart_mask_d;

    assign dl_rise_s    = ioctl_download & ~dl_q;
    assign push_s       = (state_q == LOAD) & ioctl_wr;
    assign wb_in_s.addr = ioctl_addr[ADDR_W-1:0];
    assign wb_in_s.data = ioctl_dout;
    assign unused_hi_s  = ^ioctl_addr[24:ADDR_W];

    rom_loader_wbuf u_wbuf (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push_i  (push_s),
        .din_i   (wb_in_s),
        .pop_i   (mem_ready),
        .head_o  (wb_head_s),
        .full_o  (unused_full_s),
        .empty_o (wb_empty_s),
        .drop_o  (wb_drop_s)
    );

    // Size, header detection and bank count; a download with no strobes has size 0.
    always_comb begin
        size_d = '0;
        if (any_wr_q) begin
            size_d = {1'b0, max_addr_q} + (ADDR_W+1)'(1);
        end else begin
            size_d = '0;
        end
`ifdef ROM_LOADER_HEADER_STRIP_EN
        hdr_d = (size_d[BANK_BITS-1:0] == HDR_SZ[BANK_BITS-1:0]);
`else
        hdr_d = 1'b0;
`endif
        if (hdr_d) begin
            payload_d = size_d - HDR_SZ;
        end else begin
            payload_d = size_d;
        end
        banks_d     = payload_q[ADDR_W:BANK_BITS] + (CM_W+1)'(|payload_q[BANK_BITS-1:0]);
        cart_mask_d = next_pow2_mask(banks_d);
    end

    // Load/size FSM with registered results.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            max_addr_q  <= '0;
            any_wr_q    <= 1'b0;
            payload_q   <= '0;
            hdr_q       <= 1'b0;
            cart_mask_q <= '0;
            rom_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            hdr_off_q   <= '0;
        end else begin
            dl_q <= ioctl_download;
            case (state_q)
                IDLE, READY: begin
                    if (dl_rise_s) begin
                        state_q     <= LOAD;
                        rom_valid_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        max_addr_q  <= '0;
                        any_wr_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (push_s) begin
                        any_wr_q <= 1'b1;
                        if (ioctl_addr[ADDR_W-1:0] > max_addr_q) begin
                            max_addr_q <= ioctl_addr[ADDR_W-1:0];
                        end
                    end
                    if (wb_drop_s) begin
                        overflow_q <= 1'b1;
                    end
                    if (!ioctl_download) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wb_empty_s) begin
                        state_q <= CALC1;
                    end
                end
                CALC1: begin
                    payload_q <= payload_d;
                    hdr_q     <= hdr_d;
                    state_q   <= CALC2;
                end
                CALC2: begin
                    cart_mask_q <= cart_mask_d;
                    rom_valid_q <= |payload_q;
                    hdr_off_q   <= hdr_q ? ADDR_W'(HDR_BYTES) : '0;
                    state_q     <= READY;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Registered read-address translation: bank mask then header offset, modulo 2^ADDR_W.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_rd_q    <= 1'b0;
            mem_raddr_q <= '0;
        end else begin
            mem_rd_q    <= rom_rd & rom_valid_q;
            mem_raddr_q <= {rom_a[ADDR_W-1:BANK_BITS] & cart_mask_q, rom_a[BANK_BITS-1:0]}
                           + hdr_off_q;
        end
    end

    assign mem_we    = ~wb_empty_s;
    assign mem_waddr = wb_head_s.addr;
    assign mem_din   = wb_head_s.data;
    assign mem_rd    = mem_rd_q;
    assign mem_raddr = mem_raddr_q;
    assign cart_mask = cart_mask_q;
    assign rom_valid = rom_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected writes/reads into queues,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset, ioctl_download, ioctl_wr, mem_ready, rom_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [21:0] rom_a;
    logic        mem_we, mem_rd, rom_valid, overflow;
    logic [21:0] mem_waddr, mem_raddr;
    logic [7:0]  mem_din, cart_mask;

    int checks = 0;
    int failures = 0;
    logic [29:0] wq[$];
    logic [21:0] rq[$];

    rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
        .rom_rd(rom_rd), .rom_a(rom_a), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .cart_mask(cart_mask), .rom_valid(rom_valid), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] dat(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented write pop and read strobe against the queues.
    always @(negedge clk_sys) begin
        if (mem_we && mem_ready) begin
            if (wq.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected none", mem_waddr, mem_din);
            end else begin
                check("wr", {2'b00, mem_waddr, mem_din}, {2'b00, wq.pop_front()});
            end
        end
        if (mem_rd) begin
            if (rq.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected: got addr 0x%0h expected none", mem_raddr);
            end else begin
                check("rd", {10'd0, mem_raddr}, {10'd0, rq.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_load();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [24:0] a, input logic expect_it);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = dat(a);
        if (expect_it) wq.push_back({a[21:0], dat(a)});
        tick();
    endtask

    task automatic finish_load();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        repeat (12) tick();
        check("drain_empty", wq.size(), 32'd0);
    endtask

    task automatic rd(input logic [21:0] a, input logic [21:0] exp);
        rom_rd = 1'b1;
        rom_a  = a;
        rq.push_back(exp);
        tick();
        rom_rd = 1'b0;
        tick();
    endtask

    task automatic check_result(input string name, input logic [7:0] m, input logic v, input logic o);
        check({name, "_mask"}, {24'd0, cart_mask}, {24'd0, m});
        check({name, "_valid"}, {31'd0, rom_valid}, {31'd0, v});
        check({name, "_ovf"}, {31'd0, overflow}, {31'd0, o});
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; mem_ready = 1'b0;
        rom_rd = 1'b0; ioctl_addr = '0; ioctl_dout = '0; rom_a = '0;
        repeat (3) tick();
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_raddr", {10'd0, mem_raddr}, 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        mem_ready = 1'b1;
        tick();

        // 32 KB, every byte
        start_load();
        for (int a = 0; a < 32768; a++) wr(25'(a), 1'b1);
        finish_load();
        check_result("k32", 8'h01, 1'b1, 1'b0);
        rd(22'h0C123, 22'h04123);
        rd(22'h3FFFFF, 22'h07FFF);

        // 48 KB + 512-byte header (sparse; size set by the last address)
        start_load();
        for (int a = 0; a < 49664; a += 512) wr(25'(a), 1'b1);
        wr(25'd49663, 1'b1);
        finish_load();
        check_result("k48h", 8'h03, 1'b1, 1'b0);
`ifdef ROM_LOADER_HEADER_STRIP_EN
        rd(22'h0C000, 22'h0C200);
        rd(22'h10010, 22'h00210);
        rd(22'h3FFFFF, 22'h101FF);
`else
        rd(22'h0C000, 22'h0C000);
        rd(22'h10010, 22'h00010);
        rd(22'h3FFFFF, 22'h0FFFF);
`endif

        // zero-byte download
        start_load();
        finish_load();
        check_result("zero", 8'h00, 1'b0, 1'b0);
        rom_rd = 1'b1; rom_a = 22'h00100;
        tick();
        check("zero_no_rd", {31'd0, mem_rd}, 32'd0);
        rom_rd = 1'b0;
        tick();

        // SDRAM stalls while three strobes arrive back to back
        start_load();
        mem_ready = 1'b0;
        wr(25'd0, 1'b1);
        check("stall_we1", {31'd0, mem_we}, 32'd1);
        wr(25'd1, 1'b1);
        check("stall_we2", {31'd0, mem_we}, 32'd1);
        wr(25'd2, 1'b0);
        ioctl_wr = 1'b0;
        check("stall_we3", {31'd0, mem_we}, 32'd1);
        check("stall_ovf", {31'd0, overflow}, 32'd1);
        tick();
        check("stall_we4", {31'd0, mem_we}, 32'd1);
        tick();
        check("stall_we5", {31'd0, mem_we}, 32'd1);
        mem_ready = 1'b1;
        finish_load();
        check_result("stall", 8'h00, 1'b1, 1'b1);

        // 64 KB then reload with 16 KB
        start_load();
        for (int a = 0; a < 65536; a += 1024) wr(25'(a), 1'b1);
        wr(25'd65535, 1'b1);
        finish_load();
        check_result("k64", 8'h03, 1'b1, 1'b0);
        start_load();
        check("reload_valid_drop", {31'd0, rom_valid}, 32'd0);
        check("reload_mask_held", {24'd0, cart_mask}, 32'h03);
        for (int a = 0; a < 16384; a += 1024) wr(25'(a), 1'b1);
        wr(25'h1000005, 1'b1);
        check("reload_valid_mid", {31'd0, rom_valid}, 32'd0);
        wr(25'd16383, 1'b1);
        finish_load();
        check_result("k16", 8'h00, 1'b1, 1'b0);
        rd(22'h2ABCD, 22'h02BCD);

        // reset in the middle of a load, then a clean reload
        start_load();
        for (int a = 0; a < 100; a++) wr(25'(a), 1'b1);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_valid", {31'd0, rom_valid}, 32'd0);
        reset = 1'b0;
        wq.delete();
        tick();
        check("mid_rst_we2", {31'd0, mem_we}, 32'd0);
        start_load();
        wr(25'h00000, 1'b1);
        wr(25'h04000, 1'b1);
        wr(25'h0BFFF, 1'b1);
        finish_load();
        check_result("after_rst", 8'h03, 1'b1, 1'b0);
        rd(22'h1C123, 22'h0C123);

        check("rq_empty", rq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
